// File: rtl/conv_mac_engine_pkg.sv
// Shared types and sizing helpers for the convolution MAC engine.
// Optional build macro used by the engine: CONV_RELU_EN.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_I = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } conv_state_t;

  function automatic int n_elems(input int rows, input int cols);
    return rows * cols;
  endfunction

  // Full product width plus enough headroom that N products never overflow.
  function automatic int acc_width(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

endpackage

// File: rtl/conv_mac_engine_if.sv
// Read-only port to a synchronous single-port RAM shared by kernel and image fetches.
// Handshake: ram_read_enable qualifies ram_addr; ram_data_in is valid exactly one
// cycle after an enabled address and there is no back-pressure (no ready signal).
interface conv_mac_engine_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_read_enable;
  logic [WIDTH-1:0]      ram_data_in;

  modport master (output ram_addr, output ram_read_enable, input ram_data_in);
  modport slave  (input ram_addr, input ram_read_enable, output ram_data_in);
endinterface

// File: rtl/conv_mac_engine_mac_unit.sv
// Signed multiply-accumulate stage: acc += sext(a*b) when en, cleared by clr.
// clr has priority over en; accumulation wraps modulo 2^ACC_WIDTH.
module mac_unit #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  output logic signed [ACC_WIDTH-1:0] acc
);

  logic signed [2*WIDTH-1:0]   a_ext;
  logic signed [2*WIDTH-1:0]   b_ext;
  logic signed [2*WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;

  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod  = a_ext * b_ext;

  generate
    if (ACC_WIDTH > 2 * WIDTH) begin : g_sext
      assign prod_ext = {{(ACC_WIDTH - 2 * WIDTH){prod[2*WIDTH-1]}}, prod};
    end else begin : g_trunc
      assign prod_ext = prod[ACC_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/conv_mac_engine.sv
// Convolution window engine: loads an N_ROWS x N_COLUMNS kernel, streams the image
// window through a MAC and reports one signed dot product. Macro CONV_RELU_EN clamps negatives.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int N_ROWS     = 3,
  parameter int N_COLUMNS  = 3,
  parameter int ADDR_WIDTH = 8,
  parameter int ACC_WIDTH  = acc_width(WIDTH, n_elems(N_ROWS, N_COLUMNS))
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        reload_weights,
  input  logic [ADDR_WIDTH-1:0]       w_base_addr,
  input  logic [ADDR_WIDTH-1:0]       img_base_addr,
  conv_mac_engine_if.master           ram,
  output logic                        busy,
  output logic                        done,
  output logic signed [ACC_WIDTH-1:0] result,
  output conv_state_t                 dbg_state
);

  localparam int N  = n_elems(N_ROWS, N_COLUMNS);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  conv_state_t state, next_state;

  logic [CW-1:0]               cnt;
  logic [ADDR_WIDTH-1:0]       w_base_q;
  logic [ADDR_WIDTH-1:0]       img_base_q;
  logic                        w_wr_pend;
  logic                        i_mac_pend;
  logic [CW-1:0]               pend_idx;
  logic signed [WIDTH-1:0]     weight [N];
  logic                        mac_clr;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_out;
  logic signed [ACC_WIDTH-1:0] result_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = reload_weights ? LOAD_W : LOAD_I;
      LOAD_W:  if (cnt == LAST) next_state = LOAD_I;
      LOAD_I:  if (cnt == LAST) next_state = DRAIN;
      DRAIN:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy                = (state != IDLE);
    done                = (state == DONE);
    ram.ram_read_enable = 1'b0;
    ram.ram_addr        = '0;
    mac_clr             = (state != LOAD_I) && (next_state == LOAD_I);
    dbg_state           = state;
    case (state)
      LOAD_W: begin
        ram.ram_read_enable = 1'b1;
        ram.ram_addr        = w_base_q + ADDR_WIDTH'(cnt);
      end
      LOAD_I: begin
        ram.ram_read_enable = 1'b1;
        ram.ram_addr        = img_base_q + ADDR_WIDTH'(cnt);
      end
      default: ;
    endcase
  end

  // Counter, latched bases and the one-cycle read-return pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      w_base_q   <= '0;
      img_base_q <= '0;
      w_wr_pend  <= 1'b0;
      i_mac_pend <= 1'b0;
      pend_idx   <= '0;
      result_q   <= '0;
      for (int i = 0; i < N; i++) weight[i] <= '0;
    end else begin
      if (state == IDLE && start) begin
        w_base_q   <= w_base_addr;
        img_base_q <= img_base_addr;
      end
      if (state == LOAD_W || state == LOAD_I) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      else                                    cnt <= '0;
      // Data for the address issued this cycle returns next cycle tagged with its index.
      w_wr_pend  <= (state == LOAD_W);
      i_mac_pend <= (state == LOAD_I);
      pend_idx   <= cnt;
      if (w_wr_pend) weight[pend_idx] <= ram.ram_data_in;
      if (state == DONE) result_q <= acc_out;
    end
  end

`ifdef CONV_RELU_EN
  assign acc_out = acc[ACC_WIDTH-1] ? '0 : acc;
`else
  assign acc_out = acc;
`endif

  // The new value is visible during the done pulse and held afterwards.
  assign result = (state == DONE) ? acc_out : result_q;

  mac_unit #(
    .WIDTH    (WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(mac_clr),
    .en (i_mac_pend),
    .a  (ram.ram_data_in),
    .b  (weight[pend_idx]),
    .acc(acc)
  );

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine (3x3, 8-bit) with a 1-cycle RAM model and result scoreboard.
module tb_conv_mac_engine;
  import conv_pkg::*;

  localparam int W   = 8;
  localparam int AW  = 8;
  localparam int ACC = 20;
  localparam int N   = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic reload_weights = 1'b0;
  logic [AW-1:0] w_base_addr = '0;
  logic [AW-1:0] img_base_addr = '0;
  logic busy, done;
  logic signed [ACC-1:0] result;
  conv_state_t dbg_state;

  conv_mac_engine_if #(.WIDTH(W), .ADDR_WIDTH(AW)) ram_if ();

  conv_mac_engine dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .reload_weights(reload_weights),
    .w_base_addr   (w_base_addr),
    .img_base_addr (img_base_addr),
    .ram           (ram_if),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .dbg_state     (dbg_state)
  );

  // Clock and RAM model
  always #5 clk = ~clk;

  logic [W-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_if.ram_read_enable) ram_if.ram_data_in <= mem[ram_if.ram_addr];
  end

  // Scoreboard state
  logic [ACC-1:0] exp_q[$];
  logic signed [W-1:0] kern [N];
  logic [ACC-1:0] last_exp;
  int total = 0;
  int bad = 0;
  int low_hits = 0;
  int re_outside = 0;

  task automatic check(input string tag, input longint obs, input longint exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: update resident kernel if reloading, compute expected dot product.
  function automatic logic [ACC-1:0] model_op(input bit reload, input logic [AW-1:0] wb,
                                               input logic [AW-1:0] ib);
    longint sum;
    logic [AW-1:0] a;
    sum = 0;
    for (int k = 0; k < N; k++) begin
      if (reload) begin
        a = wb + AW'(k);
        kern[k] = mem[a];
      end
      a = ib + AW'(k);
      sum += longint'(kern[k]) * longint'($signed(mem[a]));
    end
`ifdef CONV_RELU_EN
    if (sum < 0) sum = 0;
`endif
    return ACC'(sum);
  endfunction

  task automatic run_op(input string tag, input bit reload, input logic [AW-1:0] wb,
                        input logic [AW-1:0] ib, input int pulse_at);
    logic [ACC-1:0] e;
    int exp_lat, busy_cycles, lat;
    bit got;
    exp_lat = reload ? 2 * N + 2 : N + 2;
    last_exp = model_op(reload, wb, ib);
    exp_q.push_back(last_exp);
    start = 1'b1;
    reload_weights = reload;
    w_base_addr = wb;
    img_base_addr = ib;
    step();
    start = 1'b0;
    got = 1'b0;
    busy_cycles = 0;
    lat = 0;
    for (int c = 1; c <= 60 && !got; c++) begin
      if (busy) busy_cycles++;
      if (ram_if.ram_read_enable && ram_if.ram_addr <= 8'd8) low_hits++;
      if (ram_if.ram_read_enable && !busy) re_outside++;
      if (done) begin
        got = 1'b1;
        lat = c;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({tag, "_result"}, longint'($signed(result)), longint'($signed(e)));
        end else begin
          check({tag, "_sb_empty"}, 1, 0);
        end
      end else begin
        start = (c == pulse_at);
        step();
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cycles, exp_lat);
    step();
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_done"}, done, 0);
    check({tag, "_held_result"}, longint'($signed(result)), longint'($signed(last_exp)));
  endtask

  initial begin
    int dcount;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int k = 0; k < N; k++) kern[k] = '0;
    for (int k = 0; k < N; k++) mem[k] = 8'd1;
    for (int k = 0; k < N; k++) mem[16 + k] = 8'(k + 1);
    for (int k = 0; k < N; k++) mem[32 + k] = 8'd2;
    for (int k = 0; k < N; k++) mem[48 + k] = 8'hFF;
    for (int k = 0; k < N; k++) mem[64 + k] = 8'h80;
    for (int k = 0; k < N; k++) mem[80 + k] = 8'h80;
    for (int k = 0; k < 6; k++) mem[250 + k] = 8'(k + 1);

    // Reset state
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", longint'($signed(result)), 0);
    check("rst_re", ram_if.ram_read_enable, 0);
    check("rst_addr", ram_if.ram_addr, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b1;
    step();

    // Ones kernel against 1..9 image
    run_op("t1", 1'b1, 8'd0, 8'd16, 0);
    check("t1_value", longint'($signed(last_exp)), 45);

    // Reuse resident kernel, no kernel addresses touched
    low_hits = 0;
    run_op("t2", 1'b0, 8'd0, 8'd32, 0);
    check("t2_value", longint'($signed(last_exp)), 18);
    check("t2_no_kernel_fetch", low_hits, 0);

    // Negative kernel
    run_op("t3", 1'b1, 8'd48, 8'd16, 0);

    // Extremes
    run_op("t4", 1'b1, 8'd64, 8'd80, 0);
    check("t4_value", longint'($signed(last_exp)), 147456);

    // Start pulsed mid-LOAD_I is ignored
    run_op("t5", 1'b1, 8'd0, 8'd16, 12);
    dcount = 0;
    for (int c = 0; c < 25; c++) begin
      if (done) dcount++;
      step();
    end
    check("t5_single_done", dcount, 0);
    check("t5_sb_drained", exp_q.size(), 0);

    // Reset during LOAD_W clears everything, including the kernel
    start = 1'b1;
    reload_weights = 1'b1;
    w_base_addr = 8'd0;
    img_base_addr = 8'd16;
    step();
    start = 1'b0;
    dcount = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) dcount++;
      step();
    end
    check("t6_no_done_before_rst", dcount, 0);
    check("t6_mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_result", longint'($signed(result)), 0);
    check("t6_rst_re", ram_if.ram_read_enable, 0);
    check("t6_rst_state", dbg_state, IDLE);
    for (int k = 0; k < N; k++) kern[k] = '0;
    step();
    rst = 1'b1;
    step();
    run_op("t6", 1'b0, 8'd0, 8'd16, 0);
    check("t6_value", longint'($signed(last_exp)), 0);

    // Image window wrapping past the top of the address space
    run_op("t7", 1'b1, 8'd0, 8'd250, 0);
    check("t7_value", longint'($signed(last_exp)), 24);

    check("re_only_when_busy", re_outside, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_mac_engine.md
Name: conv_mac_engine

Overview:
Parametrised convolution window engine, next generation of the image/weight loader.
- Streams an N_ROWS x N_COLUMNS weight kernel from a synchronous single-port RAM into an internal register array.
- Streams the image window from the same RAM and multiply-accumulates it on the fly against the stored kernel.
- Produces one signed dot-product result per operation.
- Optionally reuses the resident kernel, so only the image is fetched.

Parameters:
WIDTH, 8, element width in bits (signed two's complement)
N_ROWS, 3, kernel/window rows
N_COLUMNS, 3, kernel/window columns
ADDR_WIDTH, 8, RAM address width
ACC_WIDTH, 2*WIDTH+$clog2(N_ROWS*N_COLUMNS), accumulator/result width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin operation; sampled only in IDLE
reload_weights  in  1  sampled with start: 1 = fetch kernel then image, 0 = reuse resident kernel
w_base_addr  in  ADDR_WIDTH  kernel base address; sampled with start
img_base_addr  in  ADDR_WIDTH  image window base address; sampled with start
ram_addr  out  ADDR_WIDTH  RAM read address
ram_read_enable  out  1  RAM read strobe
ram_data_in  in  WIDTH  RAM read data; valid one cycle after its address/strobe
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when result is updated
result  out  ACC_WIDTH  signed dot product; held until the next done

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is asynchronous and active-low.
- Reset values:
  - State: IDLE.
  - Outputs: ram_addr=0, ram_read_enable=0, busy=0, done=0, result=0.
  - Internal: weight array all 0, accumulator 0, counters 0.
- Constants: N = N_ROWS*N_COLUMNS. Element k maps to row k/N_COLUMNS, column k%N_COLUMNS (row-major).
- IDLE:
  - start=1 latches base addresses and reload_weights.
  - Next state: LOAD_W if reload_weights=1, else LOAD_I.
  - The accumulator clears on entry to LOAD_I.
- LOAD_W (N cycles):
  - Cycle k drives ram_addr = w_base_addr+k and ram_read_enable=1.
  - ram_data_in in the following cycle is written to weight[k].
  - After k = N-1, go to LOAD_I.
- LOAD_I (N cycles):
  - Cycle k drives ram_addr = img_base_addr+k and ram_read_enable=1.
  - In the following cycle: acc += sext(ram_data_in * weight[k]).
  - Overlap with LOAD_W is back-to-back: the last weight write coincides with the first image address issue.
  - After k = N-1, go to DRAIN.
- DRAIN (1 cycle):
  - ram_read_enable=0.
  - The final product is accumulated.
- DONE (1 cycle):
  - result <= acc (or its ReLU; see Optional Feature).
  - done=1.
  - Next state: IDLE.
- Latency, with start high in cycle 0:
  - done is high in cycle 2N+2 with reload_weights=1.
  - done is high in cycle N+2 with reload_weights=0.
  - busy=0 in cycle 0 and in the cycle after DONE.
- Arithmetic:
  - Product is signed WIDTH x WIDTH giving 2*WIDTH bits, sign-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH. The default ACC_WIDTH cannot overflow.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- start while busy is ignored. No queueing.
- Reuse with no kernel loaded since reset uses the all-zero array, so result=0.
- Weights persist across operations until the next LOAD_W or reset.
- rst asserted mid-operation:
  - Immediate return to IDLE and all reset values.
  - No done pulse; the partial result is discarded.
- ram_read_enable is never high outside LOAD_W and LOAD_I.

Optional Feature:
CONV_RELU_EN
- Defined: result <= (acc < 0) ? 0 : acc at DONE.
- Undefined: result <= acc unmodified, signed.
- Latency is identical in both builds.

Decomposition:
- Package conv_pkg:
  - conv_state_t enum {IDLE, LOAD_W, LOAD_I, DRAIN, DONE}.
  - Function n_elems(rows, cols).
  - Function acc_width(width, n).
- Sub-module mac_unit (parameters WIDTH, ACC_WIDTH):
  - Inputs: clk, rst, clr, en, signed a, signed b.
  - Output: registered acc.
  - clr has priority over en.
- FSM, counter, weight array and RAM interface stay in conv_mac_engine.

Test Plan:
All scenarios use 3x3, WIDTH=8, with a 1-cycle-latency RAM model.
1. RAM[0..8]=1 (kernel), RAM[16..24]=1..9; start, reload=1, w_base=0, img_base=16 -> done exactly 20 cycles after start; result=45; busy high for 20 cycles.
2. Follow-up start with reload=0, img_base=32, RAM[32..40]=2 -> done at cycle 11; result=18; no ram_addr in 0..8 driven.
3. Kernel all -1 (0xFF), image 1..9 -> result=-45 without CONV_RELU_EN; result=0 with it.
4. Extremes: kernel all -128, image all -128 -> result=147456, no wrap.
5. Second start pulsed during LOAD_I -> ignored; single done; result unchanged from the correct value.
6. rst low during LOAD_W, then released and start with reload=0 -> no done before rst; busy=0 immediately; after restart result=0 (weights cleared).
